// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the data-RAM interface.
// Turns a MEM-stage load/store request into a RAM transaction held for
// WAIT_CYCLES cycles, returns an aligned and extended load result, and
// owns the LL/SC link bit.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_i, op_i   request valid and operation code (sampled in IDLE only)
//   addr_i        byte address
//   wdata_i       right-justified store data
//   flush_i       abort any transaction, clear link bit
//   stallreq_o    stall request to pipeline controller
//   done_o        one-cycle completion pulse
//   rdata_o       load result / SC status, valid with done_o
//   misalign_o    address-error pulse, valid with done_o
//   llbit_o       current link bit
//   mem_*_o       RAM chip enable, write enable, address, byte lanes, data
//   mem_data_i    RAM read data
module mem_access_unit #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        llbit_o,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_LL  = 4'd9;
  localparam logic [3:0] OP_SC  = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [1:0]    boff_q, boff_d;
  logic [29:0]   waddr_q, waddr_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   wdat_q, wdat_d;
  logic          we_q, we_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mis_q, mis_d;
  logic          llbit_q, llbit_d;

  // Request decode on the live inputs
  logic        op_valid, is_byte, is_half, is_store, aligned, sc_fail, accept;
  logic [3:0]  sel_req;
  logic [31:0] wrep;

  always_comb begin
    op_valid = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_store = 1'b0;
    case (op_i)
      OP_LB, OP_LBU: begin op_valid = 1'b1; is_byte = 1'b1; end
      OP_LH, OP_LHU: begin op_valid = 1'b1; is_half = 1'b1; end
      OP_LW, OP_LL:  op_valid = 1'b1;
      OP_SB:         begin op_valid = 1'b1; is_byte = 1'b1; is_store = 1'b1; end
      OP_SH:         begin op_valid = 1'b1; is_half = 1'b1; is_store = 1'b1; end
      OP_SW, OP_SC:  begin op_valid = 1'b1; is_store = 1'b1; end
      default:       op_valid = 1'b0;
    endcase
    aligned = is_byte ? 1'b1 : (is_half ? ~addr_i[0] : (addr_i[1:0] == 2'b00));
    sc_fail = (op_i == OP_SC) && !llbit_q;
    accept  = (state_q == S_IDLE) && req_i && op_valid;
    // Big-endian: byte offset 0 lives in lane 3
    sel_req = is_byte ? (4'b1000 >> addr_i[1:0])
            : (is_half ? (addr_i[1] ? 4'b0011 : 4'b1100) : 4'b1111);
    if (!is_store)    wrep = '0;
    else if (is_byte) wrep = {4{wdata_i[7:0]}};
    else if (is_half) wrep = {2{wdata_i[15:0]}};
    else              wrep = wdata_i;
  end

  // Load extraction from the RAM word, using the latched offset
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ld_val;

  always_comb begin
    case (boff_q)
      2'd0:    lb = mem_data_i[31:24];
      2'd1:    lb = mem_data_i[23:16];
      2'd2:    lb = mem_data_i[15:8];
      default: lb = mem_data_i[7:0];
    endcase
    lh = boff_q[1] ? mem_data_i[15:0] : mem_data_i[31:16];
    case (op_q)
      OP_LB:        ld_val = {{24{lb[7]}}, lb};
      OP_LBU:       ld_val = {24'b0, lb};
      OP_LH:        ld_val = {{16{lh[15]}}, lh};
      OP_LHU:       ld_val = {16'b0, lh};
      OP_LW, OP_LL: ld_val = mem_data_i;
      OP_SC:        ld_val = 32'd1;
      default:      ld_val = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    boff_d  = boff_q;
    waddr_d = waddr_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    llbit_d = llbit_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!aligned) begin
            state_d = S_DONE;
            mis_d   = 1'b1;
            rdata_d = '0;
          end else if (sc_fail) begin
            state_d = S_DONE;
            rdata_d = '0;
          end else begin
            state_d = S_ACCESS;
            cnt_d   = CW'(WAIT_CYCLES - 1);
            op_d    = op_i;
            boff_d  = addr_i[1:0];
            waddr_d = addr_i[31:2];
            sel_d   = sel_req;
            wdat_d  = wrep;
            we_d    = is_store;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          rdata_d = ld_val;
          if (op_q == OP_LL) llbit_d = 1'b1;
          if (op_q == OP_SC) llbit_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        rdata_d = '0;
        mis_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush overrides every transition above
    if (flush_i) begin
      state_d = S_IDLE;
      llbit_d = 1'b0;
      rdata_d = '0;
      mis_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      boff_q  <= '0;
      waddr_q <= '0;
      sel_q   <= '0;
      wdat_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      llbit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      boff_q  <= boff_d;
      waddr_q <= waddr_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      llbit_q <= llbit_d;
    end
  end

  logic in_acc, in_done;

  always_comb begin
    in_acc     = (state_q == S_ACCESS);
    in_done    = (state_q == S_DONE);
    stallreq_o = (accept && aligned && !sc_fail) || in_acc;
    done_o     = in_done;
    rdata_o    = in_done ? rdata_q : '0;
    misalign_o = in_done && mis_q;
    llbit_o    = llbit_q;
    mem_ce_o   = in_acc;
    mem_we_o   = in_acc && we_q;
    mem_addr_o = in_acc ? {waddr_q, 2'b00} : '0;
    mem_sel_o  = in_acc ? sel_q : '0;
    mem_data_o = in_acc ? wdat_q : '0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic [3:0]  op_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] mem_data_i = '0;

  logic        stall1, done1, mis1, ll1, ce1, we1;
  logic [31:0] rdata1, addr1, mdo1;
  logic [3:0]  sel1;
  logic        stall3, done3, mis3, ll3, ce3, we3;
  logic [31:0] rdata3, addr3, mdo3;
  logic [3:0]  sel3;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .flush_i(flush_i), .stallreq_o(stall1), .done_o(done1),
    .rdata_o(rdata1), .misalign_o(mis1), .llbit_o(ll1), .mem_ce_o(ce1),
    .mem_we_o(we1), .mem_addr_o(addr1), .mem_sel_o(sel1), .mem_data_o(mdo1),
    .mem_data_i(mem_data_i)
  );

  mem_access_unit #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .flush_i(flush_i), .stallreq_o(stall3), .done_o(done3),
    .rdata_o(rdata3), .misalign_o(mis3), .llbit_o(ll3), .mem_ce_o(ce3),
    .mem_we_o(we3), .mem_addr_o(addr3), .mem_sel_o(sel3), .mem_data_o(mdo3),
    .mem_data_i(mem_data_i)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ram;
    int          lat;
    logic        ce;
    logic        we;
    logic [31:0] maddr;
    logic [3:0]  sel;
    logic [31:0] mdata;
    logic [31:0] rdata;
    logic        mis;
    logic        ll;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic void add(input string nm, input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] ram, input int lat,
                              input logic ce, input logic we, input logic [31:0] maddr,
                              input logic [3:0] sel, input logic [31:0] mdata,
                              input logic [31:0] rdata, input logic mis, input logic ll);
    vec_t v;
    v.name = nm; v.op = op; v.addr = addr; v.wdata = wdata; v.ram = ram; v.lat = lat;
    v.ce = ce; v.we = we; v.maddr = maddr; v.sel = sel; v.mdata = mdata;
    v.rdata = rdata; v.mis = mis; v.ll = ll;
    vecs.push_back(v);
  endfunction

  // One transaction on the WAIT_CYCLES=1 instance; lat counts cycles from acceptance to done_o
  task automatic run1(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      output int lat, output logic stall_acc, output logic ce_seen,
                      output logic stall_ok, output logic we, output logic [31:0] maddr,
                      output logic [3:0] sel, output logic [31:0] mdata,
                      output logic [31:0] rdata, output logic mis, output logic ll);
    logic got;
    we = 0; maddr = '0; sel = '0; mdata = '0; rdata = '0; mis = 0; ll = 0;
    ce_seen = 0; stall_ok = 1; got = 0; lat = 0;
    @(negedge clk);
    req_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wdata;
    #1 stall_acc = stall1;
    @(posedge clk);
    #1 req_i = 1'b0; op_i = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (ce1) begin
        ce_seen = 1; we = we1; maddr = addr1; sel = sel1; mdata = mdo1;
        if (!stall1) stall_ok = 0;
      end
      if (done1) begin
        rdata = rdata1; mis = mis1; ll = ll1; got = 1;
        if (stall1) stall_ok = 0;
        break;
      end
    end
    if (!got) lat = 99;
  endtask

  // One transaction on the WAIT_CYCLES=3 instance; RAM data is d1/d2/d3 in ACCESS cycles 1/2/3
  task automatic run3(input logic [3:0] op, input logic [31:0] addr,
                      input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3,
                      output int lat, output int ce_cnt, output logic addr_ok,
                      output logic [31:0] rdata, output logic ll);
    logic got;
    lat = 0; ce_cnt = 0; addr_ok = 1; rdata = '0; ll = 0; got = 0;
    mem_data_i = d1;
    @(negedge clk);
    req_i = 1'b1; op_i = op; addr_i = addr;
    @(posedge clk);
    #1 req_i = 1'b0; op_i = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      lat++;
      if (ce3) begin
        ce_cnt++;
        if (addr3 !== {addr[31:2], 2'b00} || !stall3) addr_ok = 0;
        if (ce_cnt == 2) mem_data_i = d2;
        if (ce_cnt == 3) mem_data_i = d3;
      end
      if (done3) begin
        rdata = rdata3; ll = ll3; got = 1;
        break;
      end
    end
    if (!got) lat = 99;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, ce_cnt;
    logic stall_acc, ce_seen, stall_ok, we, mis, ll, addr_ok, saw;
    logic [31:0] maddr, mdata, rdata;
    logic [3:0] sel;

    //   name      op  addr     wdata        ram          lat ce we maddr   sel      mdata        rdata        mis ll
    add("LB103",   1, 32'h103, 32'h0,       32'h80FF7F01, 2, 1, 0, 32'h100, 4'b0001, 32'h0,       32'h00000001, 0, 0);
    add("LB100",   1, 32'h100, 32'h0,       32'h80FF7F01, 2, 1, 0, 32'h100, 4'b1000, 32'h0,       32'hFFFFFF80, 0, 0);
    add("LBU100",  2, 32'h100, 32'h0,       32'h80FF7F01, 2, 1, 0, 32'h100, 4'b1000, 32'h0,       32'h00000080, 0, 0);
    add("LB101",   1, 32'h101, 32'h0,       32'h80FF7F01, 2, 1, 0, 32'h100, 4'b0100, 32'h0,       32'hFFFFFFFF, 0, 0);
    add("LB102",   1, 32'h102, 32'h0,       32'h80FF7F01, 2, 1, 0, 32'h100, 4'b0010, 32'h0,       32'h0000007F, 0, 0);
    add("LH102",   3, 32'h102, 32'h0,       32'h80FF7F01, 2, 1, 0, 32'h100, 4'b0011, 32'h0,       32'h00007F01, 0, 0);
    add("LH100",   3, 32'h100, 32'h0,       32'h80FF7F01, 2, 1, 0, 32'h100, 4'b1100, 32'h0,       32'hFFFF80FF, 0, 0);
    add("LHU100",  4, 32'h100, 32'h0,       32'h80FF7F01, 2, 1, 0, 32'h100, 4'b1100, 32'h0,       32'h000080FF, 0, 0);
    add("LW104",   5, 32'h104, 32'h0,       32'hDEADBEEF, 2, 1, 0, 32'h104, 4'b1111, 32'h0,       32'hDEADBEEF, 0, 0);
    add("SB101",   6, 32'h101, 32'h123456A5, 32'h0,       2, 1, 1, 32'h100, 4'b0100, 32'hA5A5A5A5, 32'h0,       0, 0);
    add("SH202",   7, 32'h202, 32'h1234ABCD, 32'h0,       2, 1, 1, 32'h200, 4'b0011, 32'hABCDABCD, 32'h0,       0, 0);
    add("SW300",   8, 32'h300, 32'hCAFEF00D, 32'h0,       2, 1, 1, 32'h300, 4'b1111, 32'hCAFEF00D, 32'h0,       0, 0);
    add("LWmis",   5, 32'h101, 32'h0,       32'h80FF7F01, 1, 0, 0, 32'h0,   4'b0000, 32'h0,       32'h0,       1, 0);
    add("LHmis",   3, 32'h103, 32'h0,       32'h80FF7F01, 1, 0, 0, 32'h0,   4'b0000, 32'h0,       32'h0,       1, 0);
    add("SHmis",   7, 32'h201, 32'h1111,    32'h0,        1, 0, 0, 32'h0,   4'b0000, 32'h0,       32'h0,       1, 0);
    add("SWmis",   8, 32'h302, 32'h2222,    32'h0,        1, 0, 0, 32'h0,   4'b0000, 32'h0,       32'h0,       1, 0);
    add("LL40",    9, 32'h40,  32'h0,       32'h11223344, 2, 1, 0, 32'h40,  4'b1111, 32'h0,       32'h11223344, 0, 1);
    add("SC40ok", 10, 32'h40,  32'h55,      32'h0,        2, 1, 1, 32'h40,  4'b1111, 32'h00000055, 32'h1,      0, 0);
    add("SC40no", 10, 32'h40,  32'h55,      32'h0,        1, 0, 0, 32'h0,   4'b0000, 32'h0,       32'h0,       0, 0);
    add("SC41mis",10, 32'h41,  32'h55,      32'h0,        1, 0, 0, 32'h0,   4'b0000, 32'h0,       32'h0,       1, 0);
    add("LL80",    9, 32'h80,  32'h0,       32'hA5A5A5A5, 2, 1, 0, 32'h80,  4'b1111, 32'h0,       32'hA5A5A5A5, 0, 1);
    add("SC82mis",10, 32'h82,  32'h66,      32'h0,        1, 0, 0, 32'h0,   4'b0000, 32'h0,       32'h0,       1, 1);
    add("SC80ok", 10, 32'h80,  32'h77,      32'h0,        2, 1, 1, 32'h80,  4'b1111, 32'h00000077, 32'h1,      0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.stall1", 32'(stall1), 0);
    chk("reset.done1",  32'(done1), 0);
    chk("reset.rdata1", rdata1, 0);
    chk("reset.mis1",   32'(mis1), 0);
    chk("reset.ll1",    32'(ll1), 0);
    chk("reset.ce1",    32'({ce1, we1, sel1}), 0);
    chk("reset.addr1",  addr1 | mdo1, 0);
    chk("reset.dut3",   32'({stall3, done3, mis3, ll3, ce3, we3, sel3}), 0);

    // Table-driven vectors on the WAIT_CYCLES=1 instance
    foreach (vecs[k]) begin
      mem_data_i = vecs[k].ram;
      run1(vecs[k].op, vecs[k].addr, vecs[k].wdata, lat, stall_acc, ce_seen, stall_ok,
           we, maddr, sel, mdata, rdata, mis, ll);
      chk({vecs[k].name, ".lat"},      32'(lat), 32'(vecs[k].lat));
      chk({vecs[k].name, ".stallacc"}, 32'(stall_acc), 32'(vecs[k].ce));
      chk({vecs[k].name, ".stallok"},  32'(stall_ok), 1);
      chk({vecs[k].name, ".ce"},       32'(ce_seen), 32'(vecs[k].ce));
      chk({vecs[k].name, ".rdata"},    rdata, vecs[k].rdata);
      chk({vecs[k].name, ".mis"},      32'(mis), 32'(vecs[k].mis));
      chk({vecs[k].name, ".llbit"},    32'(ll), 32'(vecs[k].ll));
      if (vecs[k].ce) begin
        chk({vecs[k].name, ".we"},    32'(we), 32'(vecs[k].we));
        chk({vecs[k].name, ".maddr"}, maddr, vecs[k].maddr);
        chk({vecs[k].name, ".sel"},   32'(sel), 32'(vecs[k].sel));
      end
      if (vecs[k].we) chk({vecs[k].name, ".mdata"}, mdata, vecs[k].mdata);
    end

    // Invalid op codes are ignored
    @(negedge clk);
    req_i = 1'b1; op_i = 4'd11; addr_i = 32'h100;
    #1 chk("nop11.stall", 32'(stall1), 0);
    @(negedge clk);
    op_i = 4'd0;
    #1 chk("nop0.stall", 32'(stall1), 0);
    saw = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done1 || ce1) saw = 1;
    end
    req_i = 1'b0;
    chk("nop.activity", 32'(saw), 0);

    // WAIT_CYCLES=3: ce held three cycles, data sampled at end of the last one
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    run3(4'd5, 32'h10, 32'h11111111, 32'h22222222, 32'h33333333, lat, ce_cnt, addr_ok, rdata, ll);
    chk("w3lw.lat",    32'(lat), 4);
    chk("w3lw.cecnt",  32'(ce_cnt), 3);
    chk("w3lw.addrok", 32'(addr_ok), 1);
    chk("w3lw.rdata",  rdata, 32'h33333333);

    // LL, then flush in the second ACCESS cycle of a following load
    run3(4'd9, 32'h20, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, lat, ce_cnt, addr_ok, rdata, ll);
    chk("w3ll.lat",   32'(lat), 4);
    chk("w3ll.rdata", rdata, 32'h0BADF00D);
    chk("w3ll.llbit", 32'(ll), 1);
    @(negedge clk);
    req_i = 1'b1; op_i = 4'd5; addr_i = 32'h24;
    @(posedge clk);
    #1 req_i = 1'b0; op_i = '0;
    @(negedge clk);
    chk("flush.acc1ce", 32'(ce3), 1);
    @(negedge clk);
    chk("flush.acc2ce", 32'(ce3), 1);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    chk("flush.ce",    32'(ce3), 0);
    chk("flush.llbit", 32'(ll3), 0);
    chk("flush.stall", 32'(stall3), 0);
    saw = 0;
    for (int i = 0; i < 5; i++) begin
      if (done3 || mis3 || ce3) saw = 1;
      @(negedge clk);
    end
    chk("flush.nodone", 32'(saw), 0);
    run3(4'd1, 32'h21, 32'h00C30000, 32'h00C30000, 32'h00C30000, lat, ce_cnt, addr_ok, rdata, ll);
    chk("postflush.lat",   32'(lat), 4);
    chk("postflush.cecnt", 32'(ce_cnt), 3);
    chk("postflush.rdata", rdata, 32'hFFFFFFC3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
